// File: rtl/blink_decision_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blink_decision_counter_pkg
//  Description : Shared constants, FSM encoding and helpers for the blink
//                decision counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package blink_decision_counter_pkg;

    localparam int ANSWER_W            = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_GAP_CYCLES      = 50000;
    localparam int DEF_MAX_BLINKS      = 7;
    localparam int DEF_TMR_W           = 16;

    // Encoding 2'd3 is unused; the FSM falls back to S_IDLE from it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [ANSWER_W-1:0] sat_inc(
        input logic [ANSWER_W-1:0] v,
        input logic [ANSWER_W-1:0] lim
    );
        return (v >= lim) ? lim : v + ANSWER_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blink_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : blink_debounce
//  Description : Two-flop synchroniser, stability-counter debouncer and
//                registered rising-edge detector for the raw blink input.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_debounce
    import blink_decision_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TMR_W           = DEF_TMR_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam logic [TMR_W-1:0] c_deb_last = TMR_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_rise;
    logic [TMR_W-1:0] r_cnt;

    // Bring the asynchronous input into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt == c_deb_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + TMR_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // One-cycle registered pulse on each accepted rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;

endmodule
`default_nettype wire

// File: rtl/blink_decision_counter.sv
`default_nettype none
// ============================================================================
//  Module      : blink_decision_counter
//  Description : Counts debounced blinks, closes a decision after an idle
//                gap and publishes the saturated count with a done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module blink_decision_counter
    import blink_decision_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int MAX_BLINKS      = DEF_MAX_BLINKS,
    parameter int TMR_W           = DEF_TMR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                blinky,
    output logic [ANSWER_W-1:0] finalAnswer,
    output logic                finalDone,
    output logic                busy
);

    localparam logic [ANSWER_W-1:0] c_max      = ANSWER_W'(MAX_BLINKS);
    localparam logic [TMR_W-1:0]    c_gap_last = TMR_W'(GAP_CYCLES - 1);

    logic                w_blink_evt;
    logic                w_level_unused;
    state_t              r_state;
    logic [ANSWER_W-1:0] r_cnt;
    logic [TMR_W-1:0]    r_gap;
    logic [ANSWER_W-1:0] r_answer;
    logic                r_done;

    blink_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .TMR_W           (TMR_W)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (blinky),
        .level_out  (w_level_unused),
        .rise_pulse (w_blink_evt)
    );

    // Decision FSM: the answer and strobe are loaded on entry to S_DONE so
    // that finalDone is high for exactly the one cycle spent in S_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_gap    <= '0;
            r_answer <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_blink_evt) begin
                        r_state <= S_COUNT;
                        r_cnt   <= ANSWER_W'(1);
                        r_gap   <= '0;
                    end
                end
                S_COUNT: begin
                    if (w_blink_evt) begin
                        // A blink on the last gap cycle still wins.
                        r_cnt <= sat_inc(r_cnt, c_max);
                        r_gap <= '0;
                    end else if (r_gap == c_gap_last) begin
                        r_state  <= S_DONE;
                        r_answer <= r_cnt;
                        r_done   <= 1'b1;
                    end else begin
                        r_gap <= r_gap + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    // A blink here opens the next decision rather than being lost.
                    if (w_blink_evt) begin
                        r_state <= S_COUNT;
                        r_cnt   <= ANSWER_W'(1);
                        r_gap   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign finalAnswer = r_answer;
    assign finalDone   = r_done;
    assign busy        = (r_state == S_COUNT);

endmodule
`default_nettype wire
